// File: rtl/fp_add_dispatch_if.sv
// Command, response and addsub-side signals of the add/sub dispatcher.
// master = dispatcher view, slave = the environment (command source, response sink, addsub unit).
interface fp_add_dispatch_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_op1;
  logic [31:0] cmd_op2;
  logic        cmd_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_timeout;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        add_start;
  logic        add_serv;
  logic        add_busy;
  logic        add_done;
  logic [31:0] add_result;
  logic        add_overflow;

  modport master (
    input  cmd_valid, cmd_op1, cmd_op2, cmd_sub, rsp_ready,
           add_busy, add_done, add_result, add_overflow,
    output cmd_ready, rsp_valid, rsp_result, rsp_overflow, rsp_timeout,
           op1, op2, add_start, add_serv
  );

  modport slave (
    output cmd_valid, cmd_op1, cmd_op2, cmd_sub, rsp_ready,
           add_busy, add_done, add_result, add_overflow,
    input  cmd_ready, rsp_valid, rsp_result, rsp_overflow, rsp_timeout,
           op1, op2, add_start, add_serv
  );
endinterface

// File: rtl/fp_add_dispatch.sv
// Queues add/sub commands and runs them one at a time through the addsub
// start/busy/done/serv handshake, returning results in command order.
module fp_add_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               n_rst,
  fp_add_dispatch_if.master bus
);
  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMR_W  = $clog2(TIMEOUT) + 1;
  localparam int ENT_W  = 2 * DATA_W + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, RESP} state_t;

  state_t              state, state_nxt;
  logic [ENT_W-1:0]    fifo_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [TMR_W-1:0]    timer;
  logic [ENT_W-1:0]    head;
  logic                push, pop, fifo_empty, fifo_full, timed_out;

  // Subtraction is A + (-B): flip the sign bit of B on the way out.
  function automatic logic [DATA_W-1:0] sign_adjust(input logic [DATA_W-1:0] v,
                                                     input logic neg);
    return {v[DATA_W-1] ^ neg, v[DATA_W-2:0]};
  endfunction

  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == CNT_W'(DEPTH));
  assign bus.cmd_ready = !fifo_full;
  assign push          = bus.cmd_valid && !fifo_full;
  assign head          = fifo_mem[rd_ptr];
  // Never launch while the unit is occupied or still holding an unserviced result.
  assign pop           = (state == IDLE) && !fifo_empty && !bus.add_busy && !bus.add_done;
  assign timed_out     = (timer == TMR_W'(TIMEOUT - 1));

  // Command storage: entry layout is {sub, op1, op2}
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {bus.cmd_sub, bus.cmd_op1, bus.cmd_op2};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.add_done)  state_nxt = ACK;
               else if (timed_out) state_nxt = RESP;
      ACK:     state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.add_start = 1'b0;
    bus.add_serv  = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      ISSUE:   bus.add_start = 1'b1;
      ACK:     bus.add_serv  = 1'b1;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand, timer and response registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.op1          <= '0;
      bus.op2          <= '0;
      timer            <= '0;
      bus.rsp_result   <= '0;
      bus.rsp_overflow <= 1'b0;
      bus.rsp_timeout  <= 1'b0;
    end else begin
      if (pop) begin
        bus.op1 <= head[2*DATA_W-1:DATA_W];
        bus.op2 <= sign_adjust(head[DATA_W-1:0], head[ENT_W-1]);
      end
      if (state == ISSUE)
        timer <= '0;
      else if (state == WAIT)
        timer <= timer + TMR_W'(1);
      // A done arriving on the last allowed cycle still counts as a real result.
      if (state == WAIT && bus.add_done) begin
        bus.rsp_result   <= bus.add_result;
        bus.rsp_overflow <= bus.add_overflow;
        bus.rsp_timeout  <= 1'b0;
      end else if (state == WAIT && timed_out) begin
        bus.rsp_result   <= '0;
        bus.rsp_overflow <= 1'b0;
        bus.rsp_timeout  <= 1'b1;
      end
    end
  end
endmodule
